// File: rtl/updown_counter_gen_pkg.sv
// Shared constants and helpers for the up/down counter family.
package updown_counter_gen_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 1;

  // Bits needed to hold a count of 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/updown_counter_gen_prescaler_tick.sv
// Enabled-cycle divider: tick is high while the count sits at N-1, so the
// enabled cycle seen with tick high is every N-th one. clr restarts the interval.
module prescaler_tick
  import updown_counter_gen_pkg::*;
#(
  parameter int N = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (N <= 1) begin : g_bypass
      logic w_unused;
      assign w_unused = clk ^ reset ^ en ^ clr;
      assign tick     = 1'b1;
    end else begin : g_count
      localparam int CW = cnt_width(N);
      localparam logic [CW-1:0] LAST = CW'(N - 1);

      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (clr) begin
          r_cnt <= '0;
        end else if (en) begin
          r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
      end

      assign tick = (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with modulus, wrap/saturate policy, parallel
// load, prescaled enable, registered ovf/udf pulses and a terminal-count flag.
module updown_counter_gen
  import updown_counter_gen_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("updown_counter_gen: WIDTH must be at least 2");
    end
    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
      $error("updown_counter_gen: MAX_VAL must lie in 1..2**WIDTH-1");
    end
    if (PRESCALE < 1) begin : g_bad_pre
      $error("updown_counter_gen: PRESCALE must be at least 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             r_udf;

  logic             w_tick;
  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_q_next;
  logic             w_ovf_next;
  logic             w_udf_next;

  // A load restarts the prescale interval, so the next step is a full interval away.
  prescaler_tick #(
    .N (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (w_tick)
  );

  assign w_step    = en & ~load & w_tick;
  assign w_at_max  = (r_q == MAX_Q);
  assign w_at_zero = (r_q == '0);

  always_comb begin
    w_q_next   = r_q;
    w_ovf_next = 1'b0;
    w_udf_next = 1'b0;
    if (load) begin
      w_q_next = (load_val > MAX_Q) ? MAX_Q : load_val;
    end else if (w_step) begin
      if (mode) begin
        if (w_at_max) begin
          w_ovf_next = 1'b1;
          w_q_next   = SAT ? r_q : '0;
        end else begin
          w_q_next = r_q + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
          w_udf_next = 1'b1;
          w_q_next   = SAT ? r_q : MAX_Q;
        end else begin
          w_q_next = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_ovf <= w_ovf_next;
      r_udf <= w_udf_next;
    end
  end

  assign q   = r_q;
  assign ovf = r_ovf;
  assign udf = r_udf;
  assign tc  = mode ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_updown_counter_gen.sv
// Bench for updown_counter_gen: three configurations (wrap, saturate, prescale 3)
// share one stimulus stream and are each compared with a reference model.
module tb_updown_counter_gen;

  localparam int W    = 4;
  localparam int MAXV = 9;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         en;
  logic         mode;
  logic         load;
  logic [W-1:0] load_val;

  logic [W-1:0] q_o   [3];
  logic         tc_o  [3];
  logic         ovf_o [3];
  logic         udf_o [3];

  updown_counter_gen #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(0), .PRESCALE(1)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .udf(udf_o[0])
  );

  updown_counter_gen #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(1), .PRESCALE(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .udf(udf_o[1])
  );

  updown_counter_gen #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(0), .PRESCALE(3)) dut_pre (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .q(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]), .udf(udf_o[2])
  );

  // Reference model: count value, enabled cycles since last step, pulses
  int m_q   [3];
  int m_en_cycles [3];
  bit m_ovf [3];
  bit m_udf [3];
  int sat_c [3] = '{0, 1, 0};
  int pre_c [3] = '{1, 1, 3};

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i] = 0; m_en_cycles[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs currently applied.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      m_ovf[i] = 0;
      m_udf[i] = 0;
      if (load) begin
        m_q[i] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        m_en_cycles[i] = 0;
      end else if (en) begin
        m_en_cycles[i]++;
        if (m_en_cycles[i] == pre_c[i]) begin
          m_en_cycles[i] = 0;
          if (mode) begin
            if (m_q[i] == MAXV) begin
              m_ovf[i] = 1;
              if (sat_c[i] == 0) m_q[i] = 0;
            end else m_q[i] = m_q[i] + 1;
          end else begin
            if (m_q[i] == 0) begin
              m_udf[i] = 1;
              if (sat_c[i] == 0) m_q[i] = MAXV;
            end else m_q[i] = m_q[i] - 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q[%0d]", i),   32'(q_o[i]),   32'(m_q[i]));
      chk($sformatf("tc[%0d]", i),  32'(tc_o[i]),
          32'(mode ? (m_q[i] == MAXV) : (m_q[i] == 0)));
      chk($sformatf("ovf[%0d]", i), 32'(ovf_o[i]), 32'(m_ovf[i]));
      chk($sformatf("udf[%0d]", i), 32'(udf_o[i]), 32'(m_udf[i]));
    end
  endtask

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset_pulse();
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("async_q0", 32'(q_o[0]), 32'd0);
    check_all();
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 1'b1; load = 1'b0; load_val = '0;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;

    // Decade wrap
    en = 1'b1; mode = 1'b1;
    for (int v = 1; v <= 9; v++) exp_q.push_back(W'(v));
    exp_q.push_back(W'(0));
    exp_q.push_back(W'(1));
    for (int k = 0; k < 11; k++) begin
      cycle();
      chk("decade_q", 32'(q_o[0]), 32'(exp_q.pop_front()));
      if (k == 8) chk("decade_tc", 32'(tc_o[0]), 32'd1);
      if (k == 9) chk("decade_ovf", 32'(ovf_o[0]), 32'd1);
    end

    // Down underflow
    load = 1'b1; load_val = '0;
    cycle();
    load = 1'b0; mode = 1'b0;
    cycle();
    chk("udf_wrap_q", 32'(q_o[0]), 32'd9);
    chk("udf_pulse", 32'(udf_o[0]), 32'd1);
    cycle();
    chk("udf_next_q", 32'(q_o[0]), 32'd8);
    chk("udf_once", 32'(udf_o[0]), 32'd0);

    // Saturation
    load = 1'b1; load_val = W'(9); mode = 1'b1;
    cycle();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("sat_hold_q", 32'(q_o[1]), 32'd9);
      chk("sat_ovf", 32'(ovf_o[1]), 32'd1);
    end
    mode = 1'b0;
    cycle();
    chk("sat_down_q", 32'(q_o[1]), 32'd8);
    chk("sat_down_ovf", 32'(ovf_o[1]), 32'd0);

    // Load clamp and priority over en
    load = 1'b1; en = 1'b1; load_val = W'(14);
    cycle();
    chk("clamp_q", 32'(q_o[0]), 32'd9);
    chk("clamp_q_pre", 32'(q_o[2]), 32'd9);
    chk("clamp_ovf", 32'(ovf_o[0]), 32'd0);
    chk("clamp_udf", 32'(udf_o[0]), 32'd0);

    // Prescaler with an en gap
    load_val = '0;
    cycle();
    load = 1'b0; mode = 1'b1;
    cycle(); cycle(); cycle();
    chk("pre_first", 32'(q_o[2]), 32'd1);
    cycle();
    en = 1'b0;
    cycle(); cycle();
    en = 1'b1;
    cycle();
    chk("pre_delayed", 32'(q_o[2]), 32'd1);
    cycle();
    chk("pre_second", 32'(q_o[2]), 32'd2);

    // Async reset mid-count
    load = 1'b1; load_val = W'(4);
    cycle();
    load = 1'b0;
    cycle();
    chk("pre_reset_q", 32'(q_o[0]), 32'd5);
    async_reset_pulse();
    cycle();
    chk("resume_1", 32'(q_o[0]), 32'd1);
    cycle();
    chk("resume_2", 32'(q_o[0]), 32'd2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      mode     = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 11) == 0);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) async_reset_pulse();
      cycle();
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_gen.md
# updown_counter_gen

Parametrised synchronous up/down counter: the general-purpose counting primitive for timers, decade/modulo counters and event tallies. It adds the following beyond a fixed 4-bit up/down counter:
- configurable width and modulus;
- wrap or saturate policy;
- synchronous parallel load;
- count enable with an optional prescaler;
- registered overflow/underflow pulses and a terminal-count flag.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2).
- MAX_VAL, 2**WIDTH-1, highest count value; range is 0..MAX_VAL (1 ≤ MAX_VAL ≤ 2**WIDTH-1).
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.
- PRESCALE, 1, counter steps once per PRESCALE enabled cycles (≥1; 1 = no prescaling).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- mode  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count: q==MAX_VAL when mode=1, q==0 when mode=0; combinational from q and mode.
- ovf  output  1  registered one-cycle pulse; q wrapped (or attempted to pass) MAX_VAL→0 going up.
- udf  output  1  registered one-cycle pulse; q wrapped (or attempted to pass) 0→MAX_VAL going down.

## Operation
- Reset values: q=0, ovf=0, udf=0, prescaler count=0.
- Priority per clock edge: load > step > hold.
- Load:
  - q ← min(load_val, MAX_VAL); prescaler count clears to 0.
  - ovf and udf are 0 on the load cycle.
  - en is ignored during load.
- Step qualifier: step = en & ~load & pre_tick. pre_tick=1 every PRESCALE-th cycle with en=1 and load=0.
  - The prescaler count advances only when en=1; it holds when en=0.
  - With PRESCALE=1, pre_tick is constantly 1.
- Up step (mode=1):
  - q<MAX_VAL: q ← q+1.
  - q==MAX_VAL, SATURATE=0: q ← 0, ovf=1.
  - q==MAX_VAL, SATURATE=1: q holds, ovf=1.
- Down step (mode=0):
  - q>0: q ← q−1.
  - q==0, SATURATE=0: q ← MAX_VAL, udf=1.
  - q==0, SATURATE=1: q holds, udf=1.
- Arithmetic:
  - Comparisons are against MAX_VAL, never the natural 2**WIDTH wrap.
  - q never holds a value >MAX_VAL.
- mode changes take effect on the next step; no state is retained per direction.
- ovf/udf are 0 on every cycle without a boundary step, including hold cycles.

## Timing
- Latency: q, ovf and udf update on the clock edge that samples load/step inputs; the new value is visible in the following cycle.
- tc follows q and mode combinationally, with no added latency.
- ovf/udf assert in the same cycle q shows the wrapped (or held) value, for exactly one cycle per boundary step.
- Back-to-back boundary steps are possible with SATURATE=1, PRESCALE=1 and en held. In that case ovf/udf stay high continuously, one pulse per step.
- Reset asserted mid-count clears all state immediately, without waiting for clk. Counting resumes from 0 on the first edge after deassertion.
- load and en both high in the same cycle: load wins and the prescaler clears.

## Structure
- Shared package: no typedefs needed. Parameter legality checks (MAX_VAL range, PRESCALE≥1) are elaboration-time assertions inside the module.
- One sub-module: prescaler_tick.
  - Parameter N; inputs clk, reset, en, clr; output tick.
  - Counts enabled cycles 0..N−1.
  - N=1 reduces to tick=1.

## Test plan
1. Decade wrap: WIDTH=4, MAX_VAL=9, SATURATE=0, mode=1, en=1 from reset.
   - q runs 0..9, then 0.
   - ovf=1 only in the cycle q returns to 0.
   - tc=1 while q=9.
2. Down underflow: same configuration, mode=0 from q=0.
   - q=9 next cycle, udf pulses once.
   - Then q runs 8, 7, …
3. Saturation: SATURATE=1, MAX_VAL=9; load 9, mode=1, en=1 for 3 cycles.
   - q stays 9.
   - ovf=1 on each of the 3 cycles.
   - Then mode=0 gives q=8, ovf=0.
4. Load clamp and priority: load=1, en=1, load_val=14 with MAX_VAL=9.
   - q=9 next cycle, no step taken, ovf=udf=0.
5. Prescaler: PRESCALE=3, en=1.
   - q increments every 3rd cycle.
   - Drop en for 2 cycles mid-interval: the step is delayed by exactly 2 cycles.
6. Async reset mid-count: at q=5, pulse reset between clock edges.
   - q=0 and ovf=udf=0 immediately.
   - Count resumes 1, 2, … after deassertion.
